// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for the multi-port register file
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  function automatic int calc_aw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int popcount(input logic [63:0] v);
    int c;
    c = 0;
    for (int k = 0; k < 64; k++) c += int'(v[k]);
    return c;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-write bits and incremental busy count
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = NREGS_DEFAULT,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = calc_aw(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NWR-1:0]    i_wr_en,
  input  logic [NWR*AW-1:0] i_wr_addr,
  input  logic              i_iss_valid,
  input  logic [AW-1:0]     i_iss_rd,
  output logic [NREGS-1:0]  o_busy,
  output logic [AW:0]       o_busy_cnt
);

  localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

  logic [NREGS-1:0] r_busy;
  logic [AW:0]      r_cnt;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_busy_nxt;
  logic [AW:0]      w_cnt_nxt;
  logic [AW-1:0]    w_waddr;
  logic             w_iss_ok;

  always_comb begin
    w_iss_ok  = i_iss_valid && !(ZERO_REG != 0 && i_iss_rd == '0);
    w_set     = '0;
    w_clr     = '0;
    w_waddr   = '0;
    w_cnt_nxt = r_cnt;
    if (w_iss_ok) begin
      w_set[i_iss_rd] = 1'b1;
      if (!r_busy[i_iss_rd]) w_cnt_nxt = w_cnt_nxt + CNT_ONE;
    end
    // A clear counts once per distinct register and only when no same-cycle issue re-arms it.
    for (int i = 0; i < NWR; i++) begin
      if (i_wr_en[i]) begin
        w_waddr = i_wr_addr[i*AW +: AW];
        if (r_busy[w_waddr] && !w_set[w_waddr] && !w_clr[w_waddr])
          w_cnt_nxt = w_cnt_nxt - CNT_ONE;
        w_clr[w_waddr] = 1'b1;
      end
    end
    w_busy_nxt = (r_busy & ~w_clr) | w_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign o_busy     = r_busy;
  assign o_busy_cnt = r_cnt;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write-through bypass and busy scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NREGS    = NREGS_DEFAULT,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = calc_aw(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NWR-1:0]      RegWEn,
  input  logic [NWR*AW-1:0]   rd_addr,
  input  logic [NWR*XLEN-1:0] rd_data,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] w_busy;
  logic [AW-1:0]    w_ra;
  logic [XLEN-1:0]  w_rdat;
  logic             w_hit;

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_en     (RegWEn),
    .i_wr_addr   (rd_addr),
    .i_iss_valid (iss_valid),
    .i_iss_rd    (iss_rd),
    .o_busy      (w_busy),
    .o_busy_cnt  (busy_cnt)
  );

  // Ports are applied in index order so the higher port wins a same-register conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (RegWEn[i] && !(ZERO_REG != 0 && rd_addr[i*AW +: AW] == '0))
          r_regs[rd_addr[i*AW +: AW]] <= rd_data[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    w_ra    = '0;
    w_rdat  = '0;
    w_hit   = 1'b0;
    for (int j = 0; j < NRD; j++) begin
      w_ra   = rs_addr[j*AW +: AW];
      w_rdat = r_regs[w_ra];
      w_hit  = 1'b0;
      for (int i = 0; i < NWR; i++) begin
        if (BYPASS != 0 && RegWEn[i] && rd_addr[i*AW +: AW] == w_ra) begin
          w_rdat = rd_data[i*XLEN +: XLEN];
          w_hit  = 1'b1;
        end
      end
      if (ZERO_REG != 0 && w_ra == '0) w_rdat = '0;
      rs_data[j*XLEN +: XLEN] = w_rdat;
      rs_busy[j]              = w_busy[w_ra] && !w_hit;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized and directed checks of regfile_mp against an array model
module tb_regfile_mp;
  import regfile_pkg::popcount;

  logic        clk;
  logic        rst_n;

  logic [1:0]  a_we;
  logic [9:0]  a_wa;
  logic [63:0] a_wd;
  logic [9:0]  a_ra;
  logic [63:0] a_rs_data;
  logic [1:0]  a_rs_busy;
  logic        a_iss_v;
  logic [4:0]  a_iss_rd;
  logic [5:0]  a_cnt;

  logic [0:0]  b_we;
  logic [4:0]  b_wa;
  logic [31:0] b_wd;
  logic [9:0]  b_ra;
  logic [63:0] b_rs_data;
  logic [1:0]  b_rs_busy;
  logic        b_iss_v;
  logic [4:0]  b_iss_rd;
  logic [5:0]  b_cnt;

  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  logic [31:0] b_regs [32];

  int total;
  int bad;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .RegWEn(a_we), .rd_addr(a_wa), .rd_data(a_wd),
    .rs_addr(a_ra), .rs_data(a_rs_data), .rs_busy(a_rs_busy),
    .iss_valid(a_iss_v), .iss_rd(a_iss_rd), .busy_cnt(a_cnt)
  );

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .ZERO_REG(1), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .RegWEn(b_we), .rd_addr(b_wa), .rd_data(b_wd),
    .rs_addr(b_ra), .rs_data(b_rs_data), .rs_busy(b_rs_busy),
    .iss_valid(b_iss_v), .iss_rd(b_iss_rd), .busy_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_a_data(input logic [4:0] ra);
    logic [31:0] v;
    v = m_regs[ra];
    for (int i = 0; i < 2; i++)
      if (a_we[i] && a_wa[i*5 +: 5] == ra) v = a_wd[i*32 +: 32];
    if (ra == 5'd0) v = 32'd0;
    return v;
  endfunction

  function automatic logic exp_a_busy(input logic [4:0] ra);
    logic w;
    w = 1'b0;
    for (int i = 0; i < 2; i++)
      if (a_we[i] && a_wa[i*5 +: 5] == ra) w = 1'b1;
    return m_busy[ra] && !w;
  endfunction

  function automatic logic [31:0] exp_b_data(input logic [4:0] ra);
    return (ra == 5'd0) ? 32'd0 : b_regs[ra];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 32; k++) begin
      m_regs[k] = 32'd0;
      b_regs[k] = 32'd0;
    end
    m_busy = 32'd0;
  endtask

  task automatic idle_inputs();
    a_we = '0; a_wa = '0; a_wd = '0; a_iss_v = 1'b0; a_iss_rd = '0;
    b_we = '0; b_wa = '0; b_wd = '0; b_iss_v = 1'b0; b_iss_rd = '0;
  endtask

  task automatic tick();
    logic [31:0] nb;
    nb = m_busy;
    for (int i = 0; i < 2; i++) if (a_we[i]) nb[a_wa[i*5 +: 5]] = 1'b0;
    if (a_iss_v && a_iss_rd != 5'd0) nb[a_iss_rd] = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 2; i++)
      if (a_we[i] && a_wa[i*5 +: 5] != 5'd0) m_regs[a_wa[i*5 +: 5]] = a_wd[i*32 +: 32];
    if (b_we[0] && b_wa != 5'd0) b_regs[b_wa] = b_wd;
    m_busy = nb;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    idle_inputs();
    a_ra = '0; b_ra = '0;
    #2 rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++) begin
      a_ra = 10'($urandom); b_ra = 10'($urandom);
      #1;
      total++;
      if (a_rs_data !== 64'd0 || a_rs_busy !== 2'b00 || a_cnt !== 6'd0) begin
        bad++;
        $display("FAIL reset_a data=%h busy=%b cnt=%0d required 0/00/0", a_rs_data, a_rs_busy, a_cnt);
      end
      total++;
      if (b_rs_data !== 64'd0 || b_cnt !== 6'd0) begin
        bad++;
        $display("FAIL reset_b data=%h cnt=%0d required 0/0", b_rs_data, b_cnt);
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_bypass();
    a_we = 2'b01; a_wa = {5'd0, 5'd3}; a_wd = {32'd0, 32'h1234_5678}; a_ra = {5'd0, 5'd3};
    b_we = 1'b1;  b_wa = 5'd3;         b_wd = 32'h1234_5678;          b_ra = {5'd0, 5'd3};
    #1;
    total++;
    if (a_rs_data[31:0] !== 32'h1234_5678) begin
      bad++;
      $display("FAIL bypass_same_cycle got=%h required=12345678", a_rs_data[31:0]);
    end
    total++;
    if (b_rs_data[31:0] !== 32'd0) begin
      bad++;
      $display("FAIL nobypass_old_value got=%h required=00000000", b_rs_data[31:0]);
    end
    tick();
    idle_inputs();
    #1;
    total++;
    if (b_rs_data[31:0] !== 32'h1234_5678 || a_rs_data[31:0] !== 32'h1234_5678) begin
      bad++;
      $display("FAIL write_after_edge a=%h b=%h required=12345678", a_rs_data[31:0], b_rs_data[31:0]);
    end
  endtask

  task automatic test_zero_reg();
    a_we = 2'b01; a_wa = '0; a_wd = {32'd0, 32'hFFFF_FFFF}; a_ra = '0;
    a_iss_v = 1'b1; a_iss_rd = 5'd0;
    #1;
    total++;
    if (a_rs_data !== 64'd0 || a_rs_busy !== 2'b00) begin
      bad++;
      $display("FAIL zero_same_cycle data=%h busy=%b required 0/00", a_rs_data, a_rs_busy);
    end
    tick();
    idle_inputs();
    #1;
    total++;
    if (a_rs_data !== 64'd0 || a_rs_busy !== 2'b00 || a_cnt !== 6'd0) begin
      bad++;
      $display("FAIL zero_after_edge data=%h busy=%b cnt=%0d required 0/00/0", a_rs_data, a_rs_busy, a_cnt);
    end
  endtask

  task automatic test_dual_write();
    a_we = 2'b11; a_wa = {5'd7, 5'd7}; a_wd = {32'h0000_5555, 32'h0000_AAAA}; a_ra = {5'd7, 5'd7};
    #1;
    total++;
    if (a_rs_data !== {32'h0000_5555, 32'h0000_5555}) begin
      bad++;
      $display("FAIL dual_bypass got=%h required=0000555500005555", a_rs_data);
    end
    tick();
    idle_inputs();
    #1;
    total++;
    if (a_rs_data[31:0] !== 32'h0000_5555) begin
      bad++;
      $display("FAIL dual_stored got=%h required=00005555", a_rs_data[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    a_ra = {5'd9, 5'd9};
    a_iss_v = 1'b1; a_iss_rd = 5'd9;
    tick();
    a_iss_v = 1'b0;
    #1;
    total++;
    if (a_rs_busy[0] !== 1'b1 || a_cnt !== 6'd1) begin
      bad++;
      $display("FAIL sb_issue busy=%b cnt=%0d required 1/1", a_rs_busy[0], a_cnt);
    end
    a_we = 2'b01; a_wa = {5'd0, 5'd9}; a_wd = {32'd0, 32'h0000_0099};
    a_iss_v = 1'b1; a_iss_rd = 5'd9;
    tick();
    idle_inputs();
    #1;
    total++;
    if (a_rs_busy[0] !== 1'b1 || a_cnt !== 6'd1) begin
      bad++;
      $display("FAIL sb_set_wins busy=%b cnt=%0d required 1/1", a_rs_busy[0], a_cnt);
    end
    a_we = 2'b01; a_wa = {5'd0, 5'd9}; a_wd = {32'd0, 32'h0000_0077};
    tick();
    idle_inputs();
    #1;
    total++;
    if (a_rs_busy[0] !== 1'b0 || a_cnt !== 6'd0) begin
      bad++;
      $display("FAIL sb_retire busy=%b cnt=%0d required 0/0", a_rs_busy[0], a_cnt);
    end
  endtask

  task automatic test_fill();
    for (int r = 1; r < 32; r++) begin
      a_iss_v = 1'b1; a_iss_rd = 5'(r);
      tick();
    end
    idle_inputs();
    #1;
    total++;
    if (a_cnt !== 6'd31) begin
      bad++;
      $display("FAIL fill_count got=%0d required=31", a_cnt);
    end
    for (int c = 0; c < 16; c++) begin
      a_we = (c < 15) ? 2'b11 : 2'b01;
      a_wa = {5'(2*c + 2), 5'(2*c + 1)};
      a_wd = {32'($urandom), 32'($urandom)};
      tick();
      total++;
      if (int'(a_cnt) != popcount({32'd0, m_busy})) begin
        bad++;
        $display("FAIL retire_step%0d got=%0d required=%0d", c, a_cnt, popcount({32'd0, m_busy}));
      end
    end
    idle_inputs();
    #1;
    total++;
    if (a_cnt !== 6'd0) begin
      bad++;
      $display("FAIL retire_done got=%0d required=0", a_cnt);
    end
  endtask

  task automatic test_random();
    logic [4:0] ra;
    for (int n = 0; n < 400; n++) begin
      a_we = 2'($urandom);
      a_wa = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      a_wd = {32'($urandom), 32'($urandom)};
      a_ra = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      a_iss_v = ($urandom_range(0, 2) == 0);
      a_iss_rd = 5'($urandom_range(0, 7));
      b_we = 1'($urandom);
      b_wa = 5'($urandom_range(0, 7));
      b_wd = 32'($urandom);
      b_ra = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #1;
      for (int j = 0; j < 2; j++) begin
        ra = a_ra[j*5 +: 5];
        total++;
        if (a_rs_data[j*32 +: 32] !== exp_a_data(ra) || a_rs_busy[j] !== exp_a_busy(ra)) begin
          bad++;
          $display("FAIL rand_a cyc%0d port%0d x%0d data=%h busy=%b required %h/%b", n, j, ra,
                   a_rs_data[j*32 +: 32], a_rs_busy[j], exp_a_data(ra), exp_a_busy(ra));
        end
        ra = b_ra[j*5 +: 5];
        total++;
        if (b_rs_data[j*32 +: 32] !== exp_b_data(ra)) begin
          bad++;
          $display("FAIL rand_b cyc%0d port%0d x%0d data=%h required %h", n, j, ra,
                   b_rs_data[j*32 +: 32], exp_b_data(ra));
        end
      end
      total++;
      if (int'(a_cnt) != popcount({32'd0, m_busy})) begin
        bad++;
        $display("FAIL rand_cnt cyc%0d got=%0d required=%0d", n, a_cnt, popcount({32'd0, m_busy}));
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    a_we = 2'b01; a_wa = {5'd0, 5'd5}; a_wd = {32'd0, 32'hDEAD_BEEF};
    a_iss_v = 1'b1; a_iss_rd = 5'd12;
    tick();
    a_we = 2'b01; a_wa = {5'd0, 5'd6}; a_wd = {32'd0, 32'h0BAD_F00D};
    a_iss_v = 1'b1; a_iss_rd = 5'd10;
    a_ra = {5'd6, 5'd5};
    #1;
    total++;
    if (a_rs_data[31:0] !== 32'hDEAD_BEEF || a_cnt === 6'd0) begin
      bad++;
      $display("FAIL pre_reset x5=%h cnt=%0d required deadbeef/nonzero", a_rs_data[31:0], a_cnt);
    end
    rst_n = 1'b0;
    model_clear();
    #1;
    total++;
    if (a_rs_data[31:0] !== 32'd0 || a_cnt !== 6'd0 || a_rs_busy !== 2'b00) begin
      bad++;
      $display("FAIL async_reset x5=%h cnt=%0d busy=%b required 0/0/00", a_rs_data[31:0], a_cnt, a_rs_busy);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b1;
    a_ra = {5'd10, 5'd6};
    #1;
    total++;
    if (a_rs_data !== 64'd0 || a_rs_busy !== 2'b00 || a_cnt !== 6'd0) begin
      bad++;
      $display("FAIL reset_discard data=%h busy=%b cnt=%0d required 0/00/0", a_rs_data, a_rs_busy, a_cnt);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_dual_write();
    test_scoreboard();
    test_fill();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file with write-through bypass and a per-register pending-write scoreboard, for the pipelined core. It replaces the single-write, two-read, 32x32 register file. It adds:
- configurable width, depth, read-port count and write-port count;
- asynchronous clear of all registers;
- same-cycle write-to-read forwarding;
- busy tracking so decode can stall on read-after-write hazards.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥2); AW = $clog2(NREGS)
- NRD, 2, number of read ports (1..4)
- NWR, 1, number of write ports (1..2)
- ZERO_REG, 1, when 1, register 0 reads as zero, ignores writes and is never busy
- BYPASS, 1, when 1, reads return same-cycle write data

Ports (vectors are packed, port i occupies slice [i*W +: W]):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- RegWEn  in  NWR  per-write-port enable
- rd_addr  in  NWR*AW  write addresses
- rd_data  in  NWR*XLEN  write data
- rs_addr  in  NRD*AW  read addresses
- rs_data  out  NRD*XLEN  read data, combinational
- rs_busy  out  NRD  read register has a pending write, combinational
- iss_valid  in  1  an instruction with a destination issues this cycle
- iss_rd  in  AW  destination register of the issuing instruction
- busy_cnt  out  AW+1  number of registers currently marked busy, registered

## Operation
- Storage: NREGS x XLEN flops.
  - Write port i updates register rd_addr[i] at the clk rising edge when RegWEn[i]=1.
  - Writes to register 0 are dropped when ZERO_REG=1.
- Write conflict: when NWR=2 and both ports target the same register, port 1 wins.
- Read:
  - rs_data[j] = 0 if ZERO_REG and rs_addr[j]=0.
  - Otherwise, if BYPASS and some enabled write port targets rs_addr[j], it is that port's rd_data. The highest-index matching port wins.
  - Otherwise it is the stored value.
- Scoreboard: one busy bit per register.
  - iss_valid sets busy[iss_rd].
  - Any enabled write to register r clears busy[r].
  - Set and clear of the same register in the same cycle: set wins, because the new producer supersedes the one retiring.
  - iss_valid with iss_rd=0 and ZERO_REG=1 is ignored.
- rs_busy[j] = busy[rs_addr[j]] AND NOT (BYPASS and a write to rs_addr[j] is enabled this cycle).
  - When BYPASS=0, rs_busy[j] = busy[rs_addr[j]].
- busy_cnt:
  - It is the population count of the busy bits after the current edge.
  - It is updated incrementally: +1 for a set of a non-busy register, −1 for each clear of a busy register.
  - It is never recomputed from the full vector in the fast path.
  - An issue and a write to the same busy register in one cycle leave busy_cnt unchanged.
- Writes to a non-busy register are legal and leave the scoreboard unchanged.
- Issuing to an already busy register is legal: the bit stays set and busy_cnt is unchanged.

## Timing
- Reset: while rst_n=0, all registers, busy bits and busy_cnt are 0. Consequently rs_data=0 and rs_busy=0 for every address. Reset takes effect immediately, independent of clk.
- Reset deassertion: the first write or issue is accepted at the first rising edge after rst_n=1.
- Reset asserted mid-cycle discards that cycle's pending writes and issues.
- Write latency: stored value is visible at the next edge; with BYPASS=1 it is visible in the same cycle.
- Scoreboard latency: busy bit is visible on rs_busy in the cycle after iss_valid.
- The block has no handshake. All inputs are sampled every edge and it never back-pressures.
- busy_cnt saturation is impossible by construction: max NREGS, or NREGS−1 with ZERO_REG.

## Structure
- regfile_pkg holds:
  - default XLEN/NREGS constants;
  - the AW function (clog2);
  - a popcount function, used only by the bench checker.
- Sub-module regfile_scoreboard holds the busy vector, the set/clear priority and the busy_cnt update logic.
- regfile_mp instantiates regfile_scoreboard and contains storage and the read/bypass muxing.

## Test plan
- Reset: write 0xDEADBEEF to x5, assert rst_n=0 asynchronously between edges.
  - Required: rs_data for x5 reads 0 immediately, and busy_cnt=0.
- Bypass: RegWEn[0]=1, rd_addr=3, rd_data=0x12345678, rs_addr[0]=3 in the same cycle.
  - BYPASS=1: rs_data[0]=0x12345678 that cycle.
  - BYPASS=0: rs_data[0] is the old value until the next edge.
- Zero register: write 0xFFFFFFFF to x0 and issue iss_rd=0.
  - Required: rs_data=0, rs_busy=0, busy_cnt stays 0.
- Dual-write conflict (NWR=2): both ports write x7, port0=0xAAAA, port1=0x5555.
  - Required: x7 reads 0x5555 after the edge, and via bypass in the same cycle.
- Scoreboard: issue x9 → next cycle rs_busy=1 and busy_cnt=1.
  - Then write x9 with iss_valid=1, iss_rd=9 in the same cycle.
  - Required: busy stays 1, busy_cnt=1.
  - Then write x9 alone → busy 0, busy_cnt=0.
- Fill: issue x1..x31 on consecutive cycles with NREGS=32, ZERO_REG=1.
  - Required: busy_cnt=31.
  - Then retire all 31 via two write ports, two per cycle → busy_cnt reaches 0 after 16 cycles.
